lane_collector: RTL

Downstream neighbour of the rotate stage: captures the 25 rotated lanes the rotate stage streams out after its output-ready pulse, holds them in a local lane array, then drains them one lane per transfer over a valid/ack handshake to the next permutation stage. It decouples the rotate stage's fixed-rate burst from a consumer that may stall, and optionally applies the pi lane reordering on the drain side.

---
 rtl/lane_collector.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lane_collector.sv
// rtl/lane_collector.sv - captures a 25-lane burst and drains it one lane per valid/ack transfer
// Define PI_REORDER_EN to drain in pi order: position (x,y) carries input lane A[(x+3y) mod 5][x].
module lane_collector #(
  parameter int LANE_W = 64,
  parameter int LANES  = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inStart,
  input  logic [LANE_W-1:0] laneIn,
  output logic              collReady,
  output logic [LANE_W-1:0] laneOut,
  output logic              laneOutValid,
  input  logic              laneOutAck,
  output logic [4:0]        laneOutIdx,
  output logic              done,
  output logic              overrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [4:0]        wp_q, wp_d;
  logic [2:0]        x_q, x_d;
  logic [2:0]        y_q, y_d;
  logic              overrun_q, overrun_d;
  logic [LANE_W-1:0] lanes_q [LANES];
  logic              xfer;
  logic              last_pos;
  logic [4:0]        src_idx;

  assign collReady    = (state_q == ST_IDLE);
  assign laneOutValid = (state_q == ST_DRAIN);
  assign xfer         = laneOutValid & laneOutAck;
  assign last_pos     = (x_q == 3'd4) && (y_q == 3'd4);
  assign done         = xfer & last_pos;
  assign overrun      = overrun_q;

  // x + 5y built from shifts and adds
  assign laneOutIdx = {2'b00, x_q} + {y_q[2:0], 2'b00} + {2'b00, y_q};

`ifdef PI_REORDER_EN
  function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 4'd5) ? 3'(s - 4'd5) : 3'(s);
  endfunction

  logic [2:0] rot;
  // (x + 3y) mod 5 accumulated one y at a time so each sum stays below 10
  assign rot     = mod5_add(mod5_add(mod5_add(x_q, y_q), y_q), y_q);
  assign src_idx = {2'b00, rot} + {x_q, 2'b00} + {2'b00, x_q};
`else
  assign src_idx = laneOutIdx;
`endif

  assign laneOut = lanes_q[src_idx];

  always_ff @(posedge clk) begin
    if (state_q == ST_CAPTURE) begin
      lanes_q[wp_q] <= laneIn;
    end
  end

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    x_d       = x_q;
    y_d       = y_q;
    overrun_d = overrun_q | (inStart & (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (inStart) begin
          state_d = ST_CAPTURE;
          wp_d    = 5'd0;
        end
      end
      ST_CAPTURE: begin
        wp_d = wp_q + 5'd1;
        if (wp_q == 5'(LANES - 1)) begin
          state_d = ST_DRAIN;
          wp_d    = 5'd0;
          x_d     = 3'd0;
          y_d     = 3'd0;
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          if (x_q == 3'd4) begin
            x_d = 3'd0;
            if (y_q == 3'd4) begin
              y_d     = 3'd0;
              state_d = ST_IDLE;
            end else begin
              y_d = y_q + 3'd1;
            end
          end else begin
            x_d = x_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wp_q      <= 5'd0;
      x_q       <= 3'd0;
      y_q       <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      x_q       <= x_d;
      y_q       <= y_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
